itch_add_order_parser: RTL and testbench
========================================

// Module: itch_add_order_parser
// PURPOSE
//  Receive side of the 9-word ITCH Add Order frame built by the quote-side encoder; feeds the order book.
//  Accepts the frame one 32-bit word per cycle (valid/ready, first-word marker) and decodes it into fields.
//  Maps the 8-byte symbol back to the 2-bit stock code and presents one decoded order per frame.
//  Drops malformed frames and counts them.
// PARAMETERS
//  REG_WIDTH     32  word width; only 32 is supported
//  ERR_CNT_WIDTH 16  width of the dropped-frame counter; saturates at all-ones
// PORTS
//  i_clk             in   1   clock, all state on rising edge
//  i_rst_n           in   1   reset, asynchronous assert, active-low
//  i_word            in   32  frame word
//  i_word_valid      in   1   i_word valid this cycle
//  i_word_first      in   1   marks word 0 of a frame; qualified by i_word_valid
//  o_word_ready      out  1   word accepted when i_word_valid && o_word_ready
//  o_msg_valid       out  1   decoded order held on outputs
//  i_msg_ready       in   1   downstream takes order when o_msg_valid && i_msg_ready
//  o_locate_code     out  16  w0[23:8]
//  o_tracking_number out  16  {w1[7:0], w0[31:24]}
//  o_timestamp       out  48  {w2[23:0], w1[31:8]}
//  o_order_ref       out  64  {w4[23:0], w3, w2[31:24]}
//  o_side            out  1   w4[24]: 0=BUY, 1=SELL
//  o_quantity        out  32  w5
//  o_stock_symbol    out  2   0 AAPL, 1 AMZN, 2 GOOGL, 3 MSFT; 0 when unknown
//  o_symbol_known    out  1   {w7,w6} matched one of the four 64-bit symbol codes
//  o_price           out  32  w8
//  o_err_count       out  ERR_CNT_WIDTH  frames dropped since reset
// BEHAVIOUR
//  - Reset: every output 0. States are IDLE, COLLECT and DISCARD. State resets to IDLE; word index resets to 0.
//  - Symbol codes {w7,w6}:
//      AAPL 64'h4141504c20202020, AMZN 64'h414d5a4e20202020,
//      GOOGL 64'h474f4f474c202020, MSFT 64'h4d53465420202020.
//  - IDLE: o_word_ready=1.
//      - An accepted word with i_word_first=0 is ignored. There is no error for it.
//      - An accepted first word with w0[7:0]==8'h41 -> COLLECT. Index becomes 1; fields are staged.
//      - An accepted first word with a type other than 8'h41 -> DISCARD with index 1. o_err_count +1.
//  - COLLECT: each accepted word is staged into shadow registers and the index increments.
//      - Word 8 accepted: the shadow copies to the output registers, o_msg_valid=1 from the next cycle, state -> IDLE.
//      - Latency: the order is visible the cycle after word 8 is accepted.
//  - DISCARD: accept and drop words until index 8 has been consumed, then go to IDLE.
//  - Mid-frame restart: an accepted word with i_word_first=1 at index 1..8 in COLLECT or DISCARD aborts the current frame.
//      - o_err_count +1 if the aborted frame was in COLLECT.
//      - The word is then handled as IDLE handles a first word, in the same cycle.
//  - Backpressure: o_word_ready = 0 only in COLLECT at index 8 while o_msg_valid && !i_msg_ready.
//      - This path is combinational from i_msg_ready.
//      - Words 0..7 are never stalled; the shadow registers allow the next frame to fill while an order is held.
//  - Output handshake: outputs are held stable while o_msg_valid && !i_msg_ready.
//      - On a take, o_msg_valid drops next cycle unless a new word 8 completes in the same cycle. In that case the new order loads and o_msg_valid stays 1.
//  - Unknown symbol: the frame is still delivered with o_symbol_known=0 and o_stock_symbol=0. It is not an error.
//  - o_err_count saturates and does not wrap. Reset mid-frame discards the partial frame and any held order.
//  - Throughput: one frame every 9 cycles at full rate with i_msg_ready=1.
// TESTING
//  - Frame: locate=16'h0102, track=16'h0304, ts=48'h00A1B2C3D4E5, ref=64'h1, BUY, qty=100, MSFT, price=32'd5000.
//      Send it back-to-back -> o_msg_valid one cycle after w8 with all fields exact, o_symbol_known=1, o_stock_symbol=3.
//  - Same frame with SELL, GOOGL, i_word_valid toggling 1/0 every cycle -> identical decode, o_side=1, o_stock_symbol=2.
//  - w0[7:0]=8'h44 with 9 words, then a good frame -> err_count=1, only the good frame is delivered.
//  - i_word_first=1 at index 5, then a complete frame -> err_count=1, only the second frame is delivered.
//  - i_msg_ready=0 over 2 full frames -> o_word_ready low at 2nd w8. Frame 1 is held stable; release -> frame 2 next cycle, no loss.
//  - Symbol 64'h5453_4C41_2020_2020 -> delivered, o_symbol_known=0. i_rst_n low at index 4 -> outputs 0, no delivery.

Source files
------------

// File: rtl/itch_add_order_parser.sv
// itch_add_order_parser: decodes 9-word ITCH Add Order frames into order fields, dropping and counting malformed frames
module itch_add_order_parser #(
  parameter int REG_WIDTH = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [REG_WIDTH-1:0]     i_word,
  input  logic                     i_word_valid,
  input  logic                     i_word_first,
  output logic                     o_word_ready,
  output logic                     o_msg_valid,
  input  logic                     i_msg_ready,
  output logic [15:0]              o_locate_code,
  output logic [15:0]              o_tracking_number,
  output logic [47:0]              o_timestamp,
  output logic [63:0]              o_order_ref,
  output logic                     o_side,
  output logic [31:0]              o_quantity,
  output logic [1:0]               o_stock_symbol,
  output logic                     o_symbol_known,
  output logic [31:0]              o_price,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);
  localparam logic [63:0] AAPL = 64'h4141504c20202020;
  localparam logic [63:0] AMZN = 64'h414d5a4e20202020;
  localparam logic [63:0] GOOGL = 64'h474f4f474c202020;
  localparam logic [63:0] MSFT = 64'h4d53465420202020;
  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [REG_WIDTH-1:0] sh [8];
  logic acc, first, abort, bad, done, known;
  logic [1:0] code;
  logic [63:0] sym;
  logic [ERR_CNT_WIDTH:0] esum;
  assign o_word_ready = !(state == COLLECT && idx == 4'd8 && o_msg_valid && !i_msg_ready);
  always_comb begin
    acc = i_word_valid && o_word_ready;
    first = acc && i_word_first;
    abort = first && state == COLLECT;
    bad = first && i_word[7:0] != 8'h41;
    done = acc && !i_word_first && state == COLLECT && idx == 4'd8;
    sym = {sh[7], sh[6]};
    known = sym == AAPL || sym == AMZN || sym == GOOGL || sym == MSFT;
    code = sym == AMZN ? 2'd1 : sym == GOOGL ? 2'd2 : sym == MSFT ? 2'd3 : 2'd0;
    esum = {1'b0, o_err_count} + (ERR_CNT_WIDTH+1)'(abort) + (ERR_CNT_WIDTH+1)'(bad);
    state_n = state;
    idx_n = idx;
    if (first) begin
      state_n = bad ? DISCARD : COLLECT;
      idx_n = 4'd1;
    end else if (acc && state != IDLE) begin
      state_n = idx == 4'd8 ? IDLE : state;
      idx_n = idx == 4'd8 ? 4'd0 : idx + 4'd1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx <= 4'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  always_ff @(posedge i_clk) begin
    if (first || (acc && state == COLLECT && idx != 4'd8)) sh[first ? 3'd0 : idx[2:0]] <= i_word;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_msg_valid <= 1'b0;
      o_err_count <= '0;
      o_locate_code <= '0;
      o_tracking_number <= '0;
      o_timestamp <= '0;
      o_order_ref <= '0;
      o_side <= 1'b0;
      o_quantity <= '0;
      o_stock_symbol <= '0;
      o_symbol_known <= 1'b0;
      o_price <= '0;
    end else begin
      o_err_count <= esum[ERR_CNT_WIDTH] ? '1 : esum[ERR_CNT_WIDTH-1:0];
      o_msg_valid <= done || (o_msg_valid && !i_msg_ready);
      if (done) begin
        o_locate_code <= sh[0][23:8];
        o_tracking_number <= {sh[1][7:0], sh[0][31:24]};
        o_timestamp <= {sh[2][23:0], sh[1][31:8]};
        o_order_ref <= {sh[4][23:0], sh[3], sh[2][31:24]};
        o_side <= sh[4][24];
        o_quantity <= sh[5];
        o_stock_symbol <= code;
        o_symbol_known <= known;
        o_price <= i_word;
      end
    end
  end
endmodule

// File: tb/tb_itch_add_order_parser.sv
// tb_itch_add_order_parser: directed scoreboard bench for the Add Order frame parser
module tb_itch_add_order_parser;
  localparam logic [63:0] AAPL = 64'h4141504c20202020;
  localparam logic [63:0] AMZN = 64'h414d5a4e20202020;
  localparam logic [63:0] GOOGL = 64'h474f4f474c202020;
  localparam logic [63:0] MSFT = 64'h4d53465420202020;
  localparam logic [63:0] UNK = 64'h54534c4120202020;
  typedef struct packed {
    logic [15:0] loc;
    logic [15:0] trk;
    logic [47:0] ts;
    logic [63:0] oref;
    logic side;
    logic [31:0] qty;
    logic [1:0] sym;
    logic known;
    logic [31:0] price;
  } ord_t;
  logic i_clk = 0, i_rst_n = 0, i_word_valid = 0, i_word_first = 0, i_msg_ready = 1;
  logic [31:0] i_word = 0;
  logic o_word_ready, o_msg_valid, o_side, o_symbol_known;
  logic [15:0] o_locate_code, o_tracking_number, o_err_count;
  logic [47:0] o_timestamp;
  logic [63:0] o_order_ref;
  logic [31:0] o_quantity, o_price;
  logic [1:0] o_stock_symbol;
  int checks = 0, errors = 0, exp_err = 0;
  ord_t q[$];
  ord_t me, a, b, g, junk, e, f, c, d, u;
  logic [31:0] fw [9];
  itch_add_order_parser dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_word(i_word), .i_word_valid(i_word_valid),
    .i_word_first(i_word_first), .o_word_ready(o_word_ready), .o_msg_valid(o_msg_valid),
    .i_msg_ready(i_msg_ready), .o_locate_code(o_locate_code), .o_tracking_number(o_tracking_number),
    .o_timestamp(o_timestamp), .o_order_ref(o_order_ref), .o_side(o_side), .o_quantity(o_quantity),
    .o_stock_symbol(o_stock_symbol), .o_symbol_known(o_symbol_known), .o_price(o_price),
    .o_err_count(o_err_count)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ord_t mk(input logic s, input logic [1:0] cd, input logic k, input logic [31:0] p, input logic [63:0] r);
    mk = '{loc: 16'h0102, trk: 16'h0304, ts: 48'h00A1B2C3D4E5, oref: r, side: s, qty: 32'd100, sym: cd, known: k, price: p};
  endfunction
  task automatic build(input ord_t o, input logic [63:0] s, input logic [7:0] t);
    fw[0] = {o.trk[7:0], o.loc, t};
    fw[1] = {o.ts[23:0], o.trk[15:8]};
    fw[2] = {o.oref[7:0], o.ts[47:24]};
    fw[3] = o.oref[39:8];
    fw[4] = {7'd0, o.side, o.oref[63:40]};
    fw[5] = o.qty;
    fw[6] = s[31:0];
    fw[7] = s[63:32];
    fw[8] = o.price;
  endtask
  task automatic idle(input int n);
    i_word_valid = 0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] w, input logic fst);
    logic ok;
    ok = 0;
    i_word = w;
    i_word_first = fst;
    i_word_valid = 1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge i_clk);
      ok = o_word_ready;
      @(posedge i_clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
    i_word_valid = 0;
  endtask
  task automatic frame(input int from, input int to, input bit gap);
    for (int i = from; i <= to; i++) begin
      send(fw[i], i == 0);
      if (gap) idle(1);
    end
  endtask
  always @(negedge i_clk) begin
    if (i_rst_n && o_msg_valid && i_msg_ready) begin
      check("sb_nonempty", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        me = q.pop_front();
        check("locate", o_locate_code, me.loc);
        check("track", o_tracking_number, me.trk);
        check("ts", o_timestamp, me.ts);
        check("ref", o_order_ref, me.oref);
        check("side", o_side, me.side);
        check("qty", o_quantity, me.qty);
        check("sym", o_stock_symbol, me.sym);
        check("known", o_symbol_known, me.known);
        check("price", o_price, me.price);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    a = mk(0, 2'd3, 1, 32'd5000, 64'h1);
    b = mk(1, 2'd2, 1, 32'd5000, 64'h1);
    junk = mk(0, 2'd0, 1, 32'd9999, 64'h5);
    g = mk(0, 2'd0, 1, 32'd7000, 64'h0123456789ABCDEF);
    e = mk(1, 2'd1, 1, 32'd6666, 64'h7);
    f = mk(1, 2'd1, 1, 32'd8000, 64'hDEADBEEFCAFEF00D);
    c = mk(0, 2'd3, 1, 32'd1111, 64'h11);
    d = mk(1, 2'd0, 1, 32'd2222, 64'h22);
    u = mk(0, 2'd0, 0, 32'd3333, 64'h33);
    #12;
    check("rst_valid", o_msg_valid, 0);
    check("rst_err", o_err_count, 0);
    check("rst_price", o_price, 0);
    check("rst_ref", o_order_ref, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1;
    idle(1);
    q.push_back(a);
    build(a, MSFT, 8'h41);
    frame(0, 8, 0);
    @(negedge i_clk);
    check("lat_valid", o_msg_valid, 1);
    @(negedge i_clk);
    check("valid_drop", o_msg_valid, 0);
    idle(1);
    q.push_back(b);
    build(b, GOOGL, 8'h41);
    frame(0, 8, 1);
    idle(2);
    send(32'h12345641, 0);
    idle(2);
    check("ignored_err", o_err_count, 0);
    check("ignored_valid", o_msg_valid, 0);
    build(junk, AAPL, 8'h44);
    frame(0, 8, 0);
    exp_err++;
    q.push_back(g);
    build(g, AAPL, 8'h41);
    frame(0, 8, 0);
    idle(2);
    check("badtype_err", o_err_count, 64'(exp_err));
    build(e, AMZN, 8'h41);
    frame(0, 4, 0);
    exp_err++;
    q.push_back(f);
    build(f, AMZN, 8'h41);
    frame(0, 8, 0);
    idle(2);
    check("restart_err", o_err_count, 64'(exp_err));
    i_msg_ready = 0;
    q.push_back(c);
    build(c, MSFT, 8'h41);
    frame(0, 8, 0);
    build(d, AAPL, 8'h41);
    frame(0, 7, 0);
    i_word = fw[8];
    i_word_first = 0;
    i_word_valid = 1;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_ready", o_word_ready, 0);
      check("bp_valid", o_msg_valid, 1);
      check("bp_hold_price", o_price, c.price);
      check("bp_hold_ref", o_order_ref, c.oref);
    end
    @(posedge i_clk);
    #1 i_msg_ready = 1;
    q.push_back(d);
    @(negedge i_clk);
    check("bp_release_ready", o_word_ready, 1);
    @(posedge i_clk);
    #1 i_word_valid = 0;
    @(negedge i_clk);
    check("bp_next_valid", o_msg_valid, 1);
    check("bp_next_price", o_price, d.price);
    idle(2);
    q.push_back(u);
    build(u, UNK, 8'h41);
    frame(0, 8, 0);
    idle(2);
    check("unk_err", o_err_count, 64'(exp_err));
    build(a, MSFT, 8'h41);
    frame(0, 3, 0);
    i_rst_n = 0;
    #2;
    check("mrst_valid", o_msg_valid, 0);
    check("mrst_err", o_err_count, 0);
    check("mrst_price", o_price, 0);
    check("mrst_qty", o_quantity, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1;
    exp_err = 0;
    frame(4, 8, 0);
    idle(3);
    check("mrst_nodeliver", o_msg_valid, 0);
    check("mrst_err_after", o_err_count, 64'(exp_err));
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
